sprite_mover: RTL

SPRITE_MOVER -- requirements
Module: sprite_mover

---
 rtl/sprite_mover.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_mover.sv
// Sprite position controller: steps a square sprite on a raster in response
// to direction requests, asking an external wall map before every move, and
// reports sprite coverage of the current raster pixel.
module sprite_mover #(
   parameter int X_W   = 10,
   parameter int Y_W   = 10,
   parameter int SPEED = 5,
   parameter int SIZE  = 5,
   parameter int X_INI = 300,
   parameter int Y_INI = 300,
   parameter int X_MIN = 0,
   parameter int X_MAX = 639,
   parameter int Y_MIN = 0,
   parameter int Y_MAX = 479
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           tick,
   input  logic           start,
   input  logic           ack,
   input  logic           win,
   input  logic           lose,
   input  logic [3:0]     dir_req,
   output logic           q_valid,
   output logic [X_W-1:0] q_x,
   output logic [Y_W-1:0] q_y,
   input  logic           q_ready,
   input  logic           q_wall,
   input  logic [X_W-1:0] hCount,
   input  logic [Y_W-1:0] vCount,
   output logic           fill,
   output logic [X_W-1:0] pos_x,
   output logic [Y_W-1:0] pos_y,
   output logic [3:0]     cur_dir,
   output logic [2:0]     state,
   output logic           overrun
);

   typedef enum logic [2:0] {
      S_INI     = 3'd0,
      S_PLAY    = 3'd1,
      S_QRY_NEW = 3'd2,
      S_QRY_CUR = 3'd3,
      S_WIN     = 3'd4,
      S_LOSE    = 3'd5
   } state_t;

   // Signed, one-bit-wider constants so targets past either edge compare correctly
   localparam logic signed [X_W:0] C_SPD_X  = (X_W+1)'(SPEED);
   localparam logic signed [Y_W:0] C_SPD_Y  = (Y_W+1)'(SPEED);
   localparam logic signed [X_W:0] C_XMIN   = (X_W+1)'(X_MIN);
   localparam logic signed [X_W:0] C_XMAX   = (X_W+1)'(X_MAX);
   localparam logic signed [Y_W:0] C_YMIN   = (Y_W+1)'(Y_MIN);
   localparam logic signed [Y_W:0] C_YMAX   = (Y_W+1)'(Y_MAX);
   localparam logic [X_W:0]        C_HALF_X = (X_W+1)'(SIZE / 2);
   localparam logic [Y_W:0]        C_HALF_Y = (Y_W+1)'(SIZE / 2);
   localparam logic [X_W-1:0]      C_XINI   = X_W'(X_INI);
   localparam logic [Y_W-1:0]      C_YINI   = Y_W'(Y_INI);

   state_t           r_state, w_state_n;
   logic [X_W-1:0]   r_pos_x, w_pos_x_n, r_q_x, w_q_x_n;
   logic [Y_W-1:0]   r_pos_y, w_pos_y_n, r_q_y, w_q_y_n;
   logic [3:0]       r_cur_dir, w_cur_dir_n, r_pend, w_pend_n, r_q_dir, w_q_dir_n;
   logic             r_q_valid, w_q_valid_n, r_overrun, w_overrun_n;

   logic                  w_new_go, w_dir_one, w_tgt_ok, w_resolved, w_blocked;
   logic [3:0]            w_qdir;
   logic signed [X_W:0]   w_tgt_x;
   logic signed [Y_W:0]   w_tgt_y;
   logic [X_W:0]          w_h_ext, w_px_ext;
   logic [Y_W:0]          w_v_ext, w_py_ext;

   // A fresh direction is only tried from PLAY; every other query re-checks cur_dir
   assign w_new_go   = (r_state == S_PLAY) && (r_pend != 4'd0) && (r_pend != r_cur_dir);
   assign w_qdir     = w_new_go ? r_pend : r_cur_dir;
   assign w_dir_one  = (dir_req != 4'd0) && ((dir_req & (dir_req - 4'd1)) == 4'd0);
   // An out-of-bounds target never raises q_valid and reads as an immediate wall
   assign w_resolved = !r_q_valid || q_ready;
   assign w_blocked  = !r_q_valid || q_wall;

   // Candidate position one step from the current position in the direction to query
   always_comb begin
      w_tgt_x = $signed({1'b0, r_pos_x});
      w_tgt_y = $signed({1'b0, r_pos_y});
      case (w_qdir)
         4'b1000: w_tgt_x = $signed({1'b0, r_pos_x}) - C_SPD_X;
         4'b0100: w_tgt_y = $signed({1'b0, r_pos_y}) - C_SPD_Y;
         4'b0010: w_tgt_x = $signed({1'b0, r_pos_x}) + C_SPD_X;
         4'b0001: w_tgt_y = $signed({1'b0, r_pos_y}) + C_SPD_Y;
         default: begin
            w_tgt_x = $signed({1'b0, r_pos_x});
            w_tgt_y = $signed({1'b0, r_pos_y});
         end
      endcase
      w_tgt_ok = (w_tgt_x >= C_XMIN) && (w_tgt_x <= C_XMAX) &&
                 (w_tgt_y >= C_YMIN) && (w_tgt_y <= C_YMAX);
   end

   // Next-state, movement and query-issue decisions
   always_comb begin
      w_state_n   = r_state;
      w_pos_x_n   = r_pos_x;
      w_pos_y_n   = r_pos_y;
      w_cur_dir_n = r_cur_dir;
      w_pend_n    = r_pend;
      w_q_valid_n = r_q_valid;
      w_q_x_n     = r_q_x;
      w_q_y_n     = r_q_y;
      w_q_dir_n   = r_q_dir;
      w_overrun_n = tick && ((r_state == S_QRY_NEW) || (r_state == S_QRY_CUR));
      case (r_state)
         S_INI: begin
            w_pos_x_n   = C_XINI;
            w_pos_y_n   = C_YINI;
            w_cur_dir_n = 4'd0;
            w_pend_n    = 4'd0;
            w_q_valid_n = 1'b0;
            if (start) begin
               w_state_n = S_PLAY;
            end else begin
               w_state_n = S_INI;
            end
         end
         S_PLAY, S_QRY_NEW, S_QRY_CUR: begin
            if (w_dir_one) begin
               w_pend_n = dir_req;
            end else begin
               w_pend_n = r_pend;
            end
            if (lose) begin
               w_state_n   = S_LOSE;
               w_q_valid_n = 1'b0;
            end else if (win) begin
               w_state_n   = S_WIN;
               w_q_valid_n = 1'b0;
            end else if (r_state == S_PLAY) begin
               if (tick && (w_new_go || (r_cur_dir != 4'd0))) begin
                  w_state_n   = w_new_go ? S_QRY_NEW : S_QRY_CUR;
                  w_q_valid_n = w_tgt_ok;
                  w_q_x_n     = w_tgt_x[X_W-1:0];
                  w_q_y_n     = w_tgt_y[Y_W-1:0];
                  w_q_dir_n   = w_qdir;
               end else begin
                  w_state_n = S_PLAY;
               end
            end else if (!w_resolved) begin
               w_state_n = r_state;
            end else if (!w_blocked) begin
               w_state_n   = S_PLAY;
               w_q_valid_n = 1'b0;
               w_pos_x_n   = r_q_x;
               w_pos_y_n   = r_q_y;
               w_cur_dir_n = r_q_dir;
            end else if ((r_state == S_QRY_NEW) && (r_cur_dir != 4'd0)) begin
               w_state_n   = S_QRY_CUR;
               w_q_valid_n = w_tgt_ok;
               w_q_x_n     = w_tgt_x[X_W-1:0];
               w_q_y_n     = w_tgt_y[Y_W-1:0];
               w_q_dir_n   = w_qdir;
            end else begin
               w_state_n   = S_PLAY;
               w_q_valid_n = 1'b0;
               w_cur_dir_n = (r_state == S_QRY_CUR) ? 4'd0 : r_cur_dir;
            end
         end
         S_WIN, S_LOSE: begin
            w_q_valid_n = 1'b0;
            if (ack) begin
               w_state_n = S_INI;
            end else begin
               w_state_n = r_state;
            end
         end
         default: begin
            w_state_n   = S_INI;
            w_q_valid_n = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset also kills an outstanding query at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_INI;
         r_pos_x   <= C_XINI;
         r_pos_y   <= C_YINI;
         r_cur_dir <= 4'd0;
         r_pend    <= 4'd0;
         r_q_valid <= 1'b0;
         r_q_x     <= '0;
         r_q_y     <= '0;
         r_q_dir   <= 4'd0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_pos_x   <= w_pos_x_n;
         r_pos_y   <= w_pos_y_n;
         r_cur_dir <= w_cur_dir_n;
         r_pend    <= w_pend_n;
         r_q_valid <= w_q_valid_n;
         r_q_x     <= w_q_x_n;
         r_q_y     <= w_q_y_n;
         r_q_dir   <= w_q_dir_n;
         r_overrun <= w_overrun_n;
      end
   end

   // Raster coverage, widened by one bit so the sprite near 0 or max never wraps
   assign w_h_ext  = {1'b0, hCount};
   assign w_v_ext  = {1'b0, vCount};
   assign w_px_ext = {1'b0, r_pos_x};
   assign w_py_ext = {1'b0, r_pos_y};
   assign fill = ((w_h_ext + C_HALF_X) >= w_px_ext) && (w_h_ext <= (w_px_ext + C_HALF_X)) &&
                 ((w_v_ext + C_HALF_Y) >= w_py_ext) && (w_v_ext <= (w_py_ext + C_HALF_Y)) &&
                 (r_state != S_INI);

   assign q_valid = r_q_valid;
   assign q_x     = r_q_x;
   assign q_y     = r_q_y;
   assign pos_x   = r_pos_x;
   assign pos_y   = r_pos_y;
   assign cur_dir = r_cur_dir;
   assign state   = r_state;
   assign overrun = r_overrun;

endmodule
